// File: rtl/ultrasonic_scheduler.sv
// Round-robin scheduler for HC-SR04-style ultrasonic sensors sharing one echo-width timer.
// Define SCHED_TIMEOUT_REPORT_EN to report timed-out/saturated slots as results.
module ultrasonic_scheduler #(
    parameter int NUM_SENSORS     = 4,
    parameter int CLK_MHZ         = 40,
    parameter int TRIG_US         = 20,
    parameter int SLOT_US         = 60000,
    parameter int RISE_TIMEOUT_US = 1000,
    parameter int MAX_ECHO_US     = 3552
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [NUM_SENSORS-1:0] sensor_mask,
    input  logic [NUM_SENSORS-1:0] echo,
    output logic [NUM_SENSORS-1:0] trig,
    output logic                   busy,
    output logic                   result_valid,
    output logic [2:0]             result_id,
    output logic [15:0]            result_us,
    output logic                   result_timeout
);

    // state     | meaning
    // IDLE      | no slot running; selects next masked sensor when enabled
    // TRIG      | trigger pulse high on the selected sensor for TRIG_US
    // WAIT_RISE | waiting for a 0->1 echo edge, bounded by RISE_TIMEOUT_US
    // MEASURE   | counting echo-high microseconds, saturating at MAX_ECHO_US
    // HOLDOFF   | waiting out the rest of the slot before the next trigger
    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_RISE,
        MEASURE,
        HOLDOFF
    } state_t;

    localparam int PW = (CLK_MHZ > 1) ? $clog2(CLK_MHZ) : 1;

    state_t                   state;
    logic [NUM_SENSORS-1:0]   echo_meta;
    logic [NUM_SENSORS-1:0]   echo_sync;
    logic [PW-1:0]            presc;
    logic                     tick;
    logic [15:0]              slot_cnt;
    logic [15:0]              phase_cnt;
    logic [15:0]              width;
    logic [2:0]               sel;
    logic                     echo_sel;
    logic                     echo_prev;
    logic                     rise;
    logic                     rec_ok;
    logic                     rec_to;
    logic                     hold_done;
    logic                     start_slot;
    logic                     nxt_found;
    logic [2:0]               nxt_sel;
    logic [NUM_SENSORS-1:0]   nxt_onehot;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            echo_meta <= '0;
            echo_sync <= '0;
        end else begin
            echo_meta <= echo;
            echo_sync <= echo_meta;
        end
    end

    assign tick      = (presc == PW'(CLK_MHZ - 1));
    assign hold_done = tick && (slot_cnt >= 16'(SLOT_US - 1));

    always_comb begin
        echo_sel = 1'b0;
        for (int j = 0; j < NUM_SENSORS; j++) begin
            if (sel == 3'(j)) echo_sel = echo_sync[j];
        end
    end

    // Next set mask bit after the pointer, wrapping; smallest distance wins.
    always_comb begin
        nxt_found  = 1'b0;
        nxt_sel    = sel;
        nxt_onehot = '0;
        for (int i = NUM_SENSORS; i >= 1; i--) begin
            for (int j = 0; j < NUM_SENSORS; j++) begin
                if (sensor_mask[j] &&
                    ((int'(sel) + i == j) || (int'(sel) + i == j + NUM_SENSORS))) begin
                    nxt_found = 1'b1;
                    nxt_sel   = 3'(j);
                end
            end
        end
        for (int j = 0; j < NUM_SENSORS; j++) begin
            nxt_onehot[j] = (nxt_sel == 3'(j));
        end
    end

    always_comb begin
        rise   = echo_sel & ~echo_prev;
        rec_ok = 1'b0;
        rec_to = 1'b0;
        if (enable) begin
            case (state)
                WAIT_RISE: begin
                    if (!rise && tick && (phase_cnt == 16'(RISE_TIMEOUT_US - 1))) rec_to = 1'b1;
                end
                MEASURE: begin
                    if (!echo_sel) rec_ok = 1'b1;
                    else if (tick && (width >= 16'(MAX_ECHO_US - 1))) rec_to = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // HOLDOFF rolls straight into the next slot so trigger spacing is exactly one slot.
    assign start_slot = enable && nxt_found &&
                        ((state == IDLE) || ((state == HOLDOFF) && hold_done));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            sel       <= 3'(NUM_SENSORS - 1);
            trig      <= '0;
            busy      <= 1'b0;
            presc     <= '0;
            slot_cnt  <= '0;
            phase_cnt <= '0;
            width     <= '0;
            echo_prev <= 1'b0;
        end else begin
            echo_prev <= echo_sel;
            presc     <= tick ? '0 : presc + PW'(1);
            if (tick) slot_cnt <= slot_cnt + 16'd1;

            if (!enable) begin
                state <= IDLE;
                trig  <= '0;
                busy  <= 1'b0;
            end else if (start_slot) begin
                state     <= TRIG;
                sel       <= nxt_sel;
                trig      <= nxt_onehot;
                busy      <= 1'b1;
                presc     <= '0;
                slot_cnt  <= '0;
                phase_cnt <= '0;
            end else begin
                case (state)
                    IDLE: ;
                    TRIG: begin
                        if (tick) begin
                            if (phase_cnt == 16'(TRIG_US - 1)) begin
                                trig      <= '0;
                                phase_cnt <= '0;
                                state     <= WAIT_RISE;
                            end else begin
                                phase_cnt <= phase_cnt + 16'd1;
                            end
                        end
                    end
                    WAIT_RISE: begin
                        if (rise) begin
                            width <= '0;
                            state <= MEASURE;
                        end else if (rec_to) begin
                            state <= HOLDOFF;
                        end else if (tick) begin
                            phase_cnt <= phase_cnt + 16'd1;
                        end
                    end
                    MEASURE: begin
                        if (rec_ok || rec_to) state <= HOLDOFF;
                        else if (tick) width <= width + 16'd1;
                    end
                    HOLDOFF: begin
                        if (hold_done) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_valid <= 1'b0;
            result_id    <= '0;
            result_us    <= '0;
        end else begin
            result_valid <= 1'b0;
            if (rec_ok) begin
                result_valid <= 1'b1;
                result_id    <= sel;
                result_us    <= width;
            end
`ifdef SCHED_TIMEOUT_REPORT_EN
            else if (rec_to) begin
                result_valid <= 1'b1;
                result_id    <= sel;
                result_us    <= 16'(MAX_ECHO_US);
            end
`endif
        end
    end

`ifdef SCHED_TIMEOUT_REPORT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)       result_timeout <= 1'b0;
        else if (rec_ok) result_timeout <= 1'b0;
        else if (rec_to) result_timeout <= 1'b1;
    end
`else
    assign result_timeout = 1'b0;
`endif

endmodule
